// File: rtl/kmeans_assign_ctrl_if.sv
// Bus bundle between the k-means assignment sequencer and its surroundings:
// start/busy/done handshake, point and centroid read ports, MAC operand and
// result path, and the nearest-centroid result.
interface kmeans_assign_ctrl_if #(
    parameter int unsigned DIM   = 4,
    parameter int unsigned K     = 3,
    parameter int unsigned DW    = 16,
    parameter int unsigned ACC_W = 36
) ();
    localparam int unsigned PW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned CW = (K * DIM > 1) ? $clog2(K * DIM) : 1;
    localparam int unsigned LW = (K > 1) ? $clog2(K) : 1;

    logic             start;
    logic             busy;
    logic             done;
    logic [PW-1:0]    pt_addr;
    logic [DW-1:0]    pt_data;
    logic [CW-1:0]    cen_addr;
    logic [DW-1:0]    cen_data;
    logic [DW-1:0]    mac_a;
    logic [DW-1:0]    mac_b;
    logic             mac_en;
    logic             mac_load;
    logic [ACC_W-1:0] mac_out;
    logic [LW-1:0]    label;
    logic [ACC_W-1:0] min_dist;

    // Sequencer side
    modport master (
        input  start, pt_data, cen_data, mac_out,
        output busy, done, pt_addr, cen_addr, mac_a, mac_b, mac_en, mac_load,
               label, min_dist
    );

    // Storage / MAC / clustering-control side
    modport slave (
        output start, pt_data, cen_data, mac_out,
        input  busy, done, pt_addr, cen_addr, mac_a, mac_b, mac_en, mac_load,
               label, min_dist
    );
endinterface

// File: rtl/kmeans_assign_ctrl.sv
// K-means assignment sequencer: walks one shared MAC through the squared
// distance from the current point to each centroid, keeps the running
// minimum and reports the nearest centroid index.
module kmeans_assign_ctrl #(
    parameter int unsigned DIM   = 4,
    parameter int unsigned K     = 3,
    parameter int unsigned DW    = 16,
    parameter int unsigned ACC_W = 36
) (
    input logic                  clk,
    input logic                  reset,
    kmeans_assign_ctrl_if.master bus
);
    localparam int unsigned PW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned CW = (K * DIM > 1) ? $clog2(K * DIM) : 1;
    localparam int unsigned LW = (K > 1) ? $clog2(K) : 1;

    localparam logic [PW-1:0] DLast = PW'(DIM - 1);
    localparam logic [LW-1:0] KLast = LW'(K - 1);

    typedef enum logic [1:0] {StIdle, StRun, StCmp, StDone} state_t;

    state_t           state_q;
    logic [PW-1:0]    d_q;
    logic [LW-1:0]    k_q;
    logic             busy_q;
    logic             done_q;
    logic             mac_en_q;
    logic             mac_load_q;
    logic [LW-1:0]    label_q;
    logic [ACC_W-1:0] min_dist_q;
    logic [DW-1:0]    abs_diff;

    // Sequencer FSM; all control outputs are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            d_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_load_q <= 1'b0;
            label_q    <= '0;
            min_dist_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q    <= StRun;
                        d_q        <= '0;
                        k_q        <= '0;
                        busy_q     <= 1'b1;
                        mac_en_q   <= 1'b1;
                        mac_load_q <= 1'b1;
                    end
                end
                StRun: begin
                    // First coordinate of each centroid restarts the accumulation
                    mac_load_q <= 1'b0;
                    if (d_q == DLast) begin
                        state_q  <= StCmp;
                        d_q      <= '0;
                        mac_en_q <= 1'b0;
                    end else begin
                        d_q <= d_q + PW'(1);
                    end
                end
                StCmp: begin
                    // Strict compare keeps the lower index on ties
                    if (k_q == '0 || bus.mac_out < min_dist_q) begin
                        min_dist_q <= bus.mac_out;
                        label_q    <= k_q;
                    end
                    if (k_q == KLast) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        k_q        <= k_q + LW'(1);
                        state_q    <= StRun;
                        mac_en_q   <= 1'b1;
                        mac_load_q <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Unsigned absolute difference of the current coordinate pair
    always_comb begin
        abs_diff = '0;
        if (bus.pt_data >= bus.cen_data) begin
            abs_diff = bus.pt_data - bus.cen_data;
        end else begin
            abs_diff = bus.cen_data - bus.pt_data;
        end
    end

    // Drive addresses from the counters and gate the MAC operands
    always_comb begin
        bus.pt_addr  = d_q;
        bus.cen_addr = CW'(32'(k_q) * DIM + 32'(d_q));
        bus.mac_a    = mac_en_q ? abs_diff : '0;
        bus.mac_b    = mac_en_q ? abs_diff : '0;
        bus.mac_en   = mac_en_q;
        bus.mac_load = mac_load_q;
        bus.busy     = busy_q;
        bus.done     = done_q;
        bus.label    = label_q;
        bus.min_dist = min_dist_q;
    end

endmodule
